timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
//   Memory-mapped countdown timer on the CPU data bus, directly downstream of the
//   mips data port (m_data_addr/byteen/wdata/rdata), selected by the bus bridge.
//   Provides CTRL/PRESET/COUNT registers with byte-enable writes, a 4-state
//   counting FSM (IDLE/LOAD/CNT/INT), and an interrupt request line back to the CPU.
// PARAMETERS
//   PRESET_RST  32'h0  reset value of PRESET
// PORTS
//   clk      in   1   system clock, all state on posedge
//   reset    in   1   asynchronous, active-low reset (0 = reset)
//   sel      in   1   bridge select: this bus access targets the timer
//   addr     in   2   word offset m_data_addr[3:2]: 0=CTRL 1=PRESET 2=COUNT 3=unused
//   byteen   in   4   byte write enables; nonzero with sel = write this cycle
//   wdata    in   32  write data, byte lanes aligned as on m_data_wdata
//   rdata    out  32  read data, combinational on addr
//   irq      out  1   interrupt request = irq_flag & CTRL.IM
// BEHAVIOUR
//   Reset (reset==0, async): CTRL=0, PRESET=PRESET_RST, COUNT=0, state=IDLE,
//     irq_flag=0, so irq=0. rdata follows regs: rdata=0 at addr 0 and 2.
//   CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x same as 00),
//     [3] IM; bits [31:4] read 0, not writable. Only byteen[0] affects CTRL.
//   Write: at posedge with sel && byteen!=0, lane k of addressed reg <= wdata lane k
//     when byteen[k]; COUNT and addr 3 writes ignored. No partial-write side effects.
//   Read: rdata = {28'b0,CTRL} / PRESET / COUNT / 0 for addr 0/1/2/3. sel not needed.
//   FSM (one transition per posedge):
//     IDLE: EN=1 -> LOAD; else stay.
//     LOAD: COUNT<=PRESET -> CNT.
//     CNT : EN=0 -> IDLE, COUNT held. Else if COUNT>1, COUNT<=COUNT-1.
//           Else (COUNT<=1), COUNT<=0, irq_flag<=1 -> INT.
//     INT : MODE 00: EN<=0 -> IDLE, irq_flag stays 1.
//           MODE 01: irq_flag<=0 -> LOAD, so irq_flag is high exactly one cycle.
//   irq_flag cleared by any CPU write to CTRL or PRESET (mode 00 acknowledge).
//   Latency: CTRL.EN written at edge 0 with PRESET=N>=1:
//     edge1 LOAD, edge2 COUNT=N, edge(N+2) COUNT=0, state INT, irq_flag=1.
//     Auto-reload period = N+2 cycles between irq pulses.
//   PRESET=0 behaves as PRESET=1: INT entered at edge 3.
//   Simultaneous events:
//     CPU CTRL write and FSM EN-clear in INT (mode 00) in same cycle:
//       CPU write wins for all CTRL bits, and irq_flag is cleared.
//     CPU write to PRESET during CNT does not change COUNT; it takes effect at next LOAD.
//     CPU clearing EN while in INT: mode 01 still goes to LOAD, then CNT sees EN=0
//       and goes to IDLE.
//     Mode change mid-count is applied at the next INT.
//   Async reset mid-count: all state returns to reset values immediately;
//     irq deasserts without waiting for clk.
//   No X on rdata/irq after reset; COUNT never underflows below 0.
// TESTING
//   1 Reset: hold reset=0 and toggle clk -> rdata=0 at addr 0/2, PRESET=PRESET_RST,
//     irq=0; release, no activity -> state IDLE.
//   2 Byte writes: write PRESET=32'h11223344, then byteen=4'b0010 wdata=32'h0000AA00
//     -> PRESET reads 32'h1122AA44; COUNT write 32'hFFFFFFFF -> COUNT still 0.
//   3 One-shot: PRESET=5, CTRL=4'b1001 -> COUNT=5 after edge2, COUNT=1 after edge6,
//     irq=1 after edge7, CTRL reads 4'b1000 after edge8; CTRL write clears irq.
//   4 Auto-reload: PRESET=3, CTRL=4'b1011 -> irq one-cycle pulses every 5 cycles,
//     first pulse after edge5; IM=0 run -> irq stays 0, COUNT sequence unchanged.
//   5 Abort/edges: clear EN during CNT at COUNT=7 -> IDLE, COUNT holds 7;
//     PRESET=0 -> INT at edge3; assert reset mid-count -> COUNT=0, irq=0 asynchronously.
//   6 Collision: in mode 00, write CTRL=4'b1001 on the INT edge -> EN stays 1,
//     irq_flag=0, FSM reloads via IDLE->LOAD.

Source files
------------

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and an
// interrupt request. Counts down from PRESET once enabled, raises irq_flag on
// expiry, and either stops (one-shot) or reloads (auto-reload).
module timer_counter #(
    parameter logic [31:0] PRESET_RST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCnt,
        StInt
    } state_e;

    state_e      state_q;
    logic [3:0]  ctrl_q;     // [0] EN, [2:1] MODE, [3] IM
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_flag_q;

    logic        wr_access;
    logic        wr_ctrl;
    logic        wr_preset;
    logic [31:0] preset_merged;
    logic        ctrl_en;
    logic        mode_reload;

    assign wr_access   = sel && (byteen != 4'b0000);
    assign wr_ctrl     = wr_access && (addr == ADDR_CTRL);
    assign wr_preset   = wr_access && (addr == ADDR_PRESET);
    assign ctrl_en     = ctrl_q[0];
    // MODE 1x behaves like one-shot, so only 01 selects auto-reload.
    assign mode_reload = (ctrl_q[2:1] == 2'b01);

    // Merge the enabled byte lanes of wdata into the current PRESET value.
    always_comb begin
        preset_merged = preset_q;
        for (int k = 0; k < 4; k++) begin
            if (byteen[k]) begin
                preset_merged[8*k +: 8] = wdata[8*k +: 8];
            end
        end
    end

    // Register file and counting FSM; later assignments take priority, which
    // gives CPU CTRL writes precedence over the FSM's EN clear and lets an
    // expiry set irq_flag even if a write acknowledges in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ctrl_q     <= 4'b0000;
            preset_q   <= PRESET_RST;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            // Any CPU write to CTRL or PRESET acknowledges the interrupt.
            if (wr_ctrl || wr_preset) begin
                irq_flag_q <= 1'b0;
            end
            if (wr_preset) begin
                preset_q <= preset_merged;
            end

            unique case (state_q)
                StIdle: begin
                    if (ctrl_en) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    count_q <= preset_q;
                    state_q <= StCnt;
                end
                StCnt: begin
                    if (!ctrl_en) begin
                        state_q <= StIdle;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        // PRESET of 0 or 1 both expire here without underflow.
                        count_q    <= 32'd0;
                        irq_flag_q <= 1'b1;
                        state_q    <= StInt;
                    end
                end
                StInt: begin
                    if (mode_reload) begin
                        irq_flag_q <= 1'b0;
                        state_q    <= StLoad;
                    end else begin
                        ctrl_q[0] <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (wr_ctrl && byteen[0]) begin
                ctrl_q <= wdata[3:0];
            end
        end
    end

    // Read mux, combinational on addr; sel is not required for reads.
    always_comb begin
        case (addr)
            ADDR_CTRL:   rdata = {28'b0, ctrl_q};
            ADDR_PRESET: rdata = preset_q;
            ADDR_COUNT:  rdata = count_q;
            default:     rdata = 32'd0;
        endcase
    end

    // Interrupt is masked by CTRL.IM.
    assign irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus a randomized
// run compared against a behavioural model.
module tb_timer_counter;

    localparam logic [31:0] PRESET_RST = 32'h0000_0004;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        sel    = 1'b0;
    logic [1:0]  addr   = 2'd0;
    logic [3:0]  byteen = 4'd0;
    logic [31:0] wdata  = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    timer_counter #(
        .PRESET_RST(PRESET_RST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .byteen(byteen),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1);
    end

    // ---------------- helpers (all return 1 time unit after a posedge) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        sel    = 1'b1;
        addr   = a;
        byteen = be;
        wdata  = d;
        @(posedge clk);
        #1;
        sel    = 1'b0;
        byteen = 4'd0;
        wdata  = 32'd0;
    endtask

    task automatic do_reset();
        sel    = 1'b0;
        byteen = 4'd0;
        reset  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    // ---------------- behavioural model ----------------
    // Phases of the timer's life: waiting for enable, loading, counting, expired.
    localparam int PH_WAIT = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_EXP  = 3;

    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    longint      m_count;
    bit          m_flag;
    int          m_phase;

    task automatic model_init();
        m_ctrl   = 4'd0;
        m_preset = PRESET_RST;
        m_count  = 0;
        m_flag   = 0;
        m_phase  = PH_WAIT;
    endtask

    // Advance the model by one clock edge given the bus inputs currently driven.
    task automatic model_step();
        bit          wr;
        logic [3:0]  n_ctrl;
        logic [31:0] n_preset;
        longint      n_count;
        bit          n_flag;
        int          n_phase;
        wr       = sel && (byteen != 4'd0);
        n_ctrl   = m_ctrl;
        n_preset = m_preset;
        n_count  = m_count;
        n_flag   = m_flag;
        n_phase  = m_phase;
        if (wr && (addr == 2'd0 || addr == 2'd1)) n_flag = 0;
        if (wr && addr == 2'd1) begin
            for (int k = 0; k < 4; k++)
                if (byteen[k]) n_preset[8*k +: 8] = wdata[8*k +: 8];
        end
        if (m_phase == PH_WAIT) begin
            if (m_ctrl[0]) n_phase = PH_LOAD;
        end else if (m_phase == PH_LOAD) begin
            n_count = longint'(m_preset);
            n_phase = PH_RUN;
        end else if (m_phase == PH_RUN) begin
            if (!m_ctrl[0]) n_phase = PH_WAIT;
            else if (m_count >= 2) n_count = m_count - 1;
            else begin
                n_count = 0;
                n_flag  = 1;
                n_phase = PH_EXP;
            end
        end else begin
            if (m_ctrl[2:1] == 2'b01) begin
                n_flag  = 0;
                n_phase = PH_LOAD;
            end else begin
                n_ctrl[0] = 1'b0;
                n_phase   = PH_WAIT;
            end
        end
        if (wr && addr == 2'd0 && byteen[0]) n_ctrl = wdata[3:0];
        m_ctrl   = n_ctrl;
        m_preset = n_preset;
        m_count  = n_count;
        m_flag   = n_flag;
        m_phase  = n_phase;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        reset  = 1'b0;
        sel    = 1'b1;
        addr   = 2'd0;
        byteen = 4'hF;
        wdata  = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        sel    = 1'b0;
        byteen = 4'd0;
        rd(2'd0, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_ctrl: got %h want %h", d, 32'd0); end
        rd(2'd1, d);
        total++; if (d !== PRESET_RST) begin bad++; $display("FAIL reset_preset: got %h want %h", d, PRESET_RST); end
        rd(2'd2, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_count: got %h want %h", d, 32'd0); end
        rd(2'd3, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_unused: got %h want %h", d, 32'd0); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) tick();
        rd(2'd2, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_idle_count: got %h want %h", d, 32'd0); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_idle_irq: got %b want 0", irq); end
    endtask

    task automatic test_byte_writes();
        logic [31:0] d;
        do_reset();
        bus_wr(2'd1, 4'hF, 32'h1122_3344);
        bus_wr(2'd1, 4'b0010, 32'h0000_AA00);
        rd(2'd1, d);
        total++; if (d !== 32'h1122_AA44) begin bad++; $display("FAIL byte_preset: got %h want %h", d, 32'h1122_AA44); end
        bus_wr(2'd2, 4'hF, 32'hFFFF_FFFF);
        rd(2'd2, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL count_readonly: got %h want %h", d, 32'd0); end
        bus_wr(2'd3, 4'hF, 32'hFFFF_FFFF);
        rd(2'd3, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL addr3_read: got %h want %h", d, 32'd0); end
        bus_wr(2'd0, 4'b1110, 32'hFFFF_FFFF);
        rd(2'd0, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL ctrl_upper_lanes: got %h want %h", d, 32'd0); end
        bus_wr(2'd0, 4'b0001, 32'hFFFF_FFF8);
        rd(2'd0, d);
        total++; if (d !== 32'h8) begin bad++; $display("FAIL ctrl_lane0: got %h want %h", d, 32'h8); end
        // Write strobes without sel must be ignored.
        sel    = 1'b0;
        addr   = 2'd1;
        byteen = 4'hF;
        wdata  = 32'hDEAD_BEEF;
        tick();
        byteen = 4'd0;
        rd(2'd1, d);
        total++; if (d !== 32'h1122_AA44) begin bad++; $display("FAIL nosel_write: got %h want %h", d, 32'h1122_AA44); end
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        logic [31:0] exp_cnt;
        logic        exp_irq;
        do_reset();
        bus_wr(2'd1, 4'hF, 32'd5);
        bus_wr(2'd0, 4'hF, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_cnt = (k >= 2 && k <= 6) ? 32'(7 - k) : 32'd0;
            exp_irq = (k >= 7);
            rd(2'd2, d);
            total++; if (d !== exp_cnt) begin bad++; $display("FAIL oneshot_count edge%0d: got %0d want %0d", k, d, exp_cnt); end
            total++; if (irq !== exp_irq) begin bad++; $display("FAIL oneshot_irq edge%0d: got %b want %b", k, irq, exp_irq); end
        end
        rd(2'd0, d);
        total++; if (d !== 32'h8) begin bad++; $display("FAIL oneshot_en_cleared: got %h want %h", d, 32'h8); end
        bus_wr(2'd0, 4'hF, 32'h8);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_ack: got %b want 0", irq); end
        repeat (3) tick();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_stays_idle: got %b want 0", irq); end
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        logic [31:0] exp_cnt;
        logic        exp_irq;
        int          p;
        for (int run = 0; run < 2; run++) begin
            do_reset();
            bus_wr(2'd1, 4'hF, 32'd3);
            bus_wr(2'd0, 4'hF, (run == 0) ? 32'hB : 32'h3);
            for (int k = 1; k <= 16; k++) begin
                tick();
                // Period of 5 edges: COUNT 3,2,1,0(INT),0(LOAD) starting at edge 2.
                p       = (k - 2) % 5;
                exp_cnt = (k >= 2 && p <= 3) ? 32'(3 - p) : 32'd0;
                exp_irq = (run == 0) && (k >= 5) && ((k - 5) % 5 == 0);
                rd(2'd2, d);
                total++; if (d !== exp_cnt) begin bad++; $display("FAIL reload_count run%0d edge%0d: got %0d want %0d", run, k, d, exp_cnt); end
                total++; if (irq !== exp_irq) begin bad++; $display("FAIL reload_irq run%0d edge%0d: got %b want %b", run, k, irq, exp_irq); end
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        do_reset();
        bus_wr(2'd1, 4'hF, 32'd10);
        bus_wr(2'd0, 4'hF, 32'h1);
        repeat (4) tick();
        bus_wr(2'd0, 4'hF, 32'h0);
        rd(2'd2, d);
        total++; if (d !== 32'd7) begin bad++; $display("FAIL abort_count: got %0d want 7", d); end
        repeat (3) tick();
        rd(2'd2, d);
        total++; if (d !== 32'd7) begin bad++; $display("FAIL abort_hold: got %0d want 7", d); end
        bus_wr(2'd0, 4'hF, 32'h1);
        tick();
        rd(2'd2, d);
        total++; if (d !== 32'd7) begin bad++; $display("FAIL restart_load_edge: got %0d want 7", d); end
        tick();
        rd(2'd2, d);
        total++; if (d !== 32'd10) begin bad++; $display("FAIL restart_reload: got %0d want 10", d); end
    endtask

    task automatic test_preset_zero();
        logic [31:0] d;
        do_reset();
        bus_wr(2'd1, 4'hF, 32'd0);
        bus_wr(2'd0, 4'hF, 32'h9);
        repeat (2) tick();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL pzero_edge2_irq: got %b want 0", irq); end
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL pzero_edge3_irq: got %b want 1", irq); end
        rd(2'd2, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL pzero_count: got %0d want 0", d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        do_reset();
        bus_wr(2'd1, 4'hF, 32'd20);
        bus_wr(2'd0, 4'hF, 32'h9);
        repeat (5) tick();
        rd(2'd2, d);
        total++; if (d !== 32'd17) begin bad++; $display("FAIL areset_precount: got %0d want 17", d); end
        #1 reset = 1'b0;
        rd(2'd2, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL areset_count: got %0d want 0", d); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        bus_wr(2'd1, 4'hF, 32'd1);
        bus_wr(2'd0, 4'hF, 32'h9);
        repeat (3) tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL areset_irq_before: got %b want 1", irq); end
        #2 reset = 1'b0;
        #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL areset_irq: got %b want 0", irq); end
        rd(2'd0, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL areset_ctrl: got %h want 0", d); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_collision();
        logic [31:0] d;
        do_reset();
        bus_wr(2'd1, 4'hF, 32'd2);
        bus_wr(2'd0, 4'hF, 32'h9);
        repeat (4) tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL coll_int_reached: got %b want 1", irq); end
        bus_wr(2'd0, 4'hF, 32'h9);
        rd(2'd0, d);
        total++; if (d !== 32'h9) begin bad++; $display("FAIL coll_ctrl_wins: got %h want %h", d, 32'h9); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL coll_flag_cleared: got %b want 0", irq); end
        repeat (2) tick();
        rd(2'd2, d);
        total++; if (d !== 32'd2) begin bad++; $display("FAIL coll_reload: got %0d want 2", d); end
        repeat (2) tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL coll_second_int: got %b want 1", irq); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int          r;
        do_reset();
        model_init();
        for (int cyc = 0; cyc < 400; cyc++) begin
            r = int'($urandom_range(0, 15));
            if (r < 2) begin
                sel    = 1'b1;
                addr   = 2'd0;
                byteen = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
                wdata  = $urandom;
            end else if (r == 2) begin
                sel    = 1'b1;
                addr   = 2'd1;
                byteen = ($urandom_range(0, 1) == 0) ? 4'hF : 4'b0001;
                wdata  = 32'($urandom_range(0, 6));
            end else if (r == 3) begin
                sel    = 1'($urandom_range(0, 1));
                addr   = 2'($urandom_range(2, 3));
                byteen = 4'hF;
                wdata  = $urandom;
            end else if (r == 4) begin
                sel    = 1'b0;
                addr   = 2'($urandom_range(0, 1));
                byteen = 4'hF;
                wdata  = $urandom;
            end else begin
                sel    = 1'b0;
                byteen = 4'd0;
            end
            model_step();
            tick();
            sel    = 1'b0;
            byteen = 4'd0;
            rd(2'd0, d);
            total++; if (d !== {28'd0, m_ctrl}) begin bad++; $display("FAIL rand_ctrl cyc%0d: got %h want %h", cyc, d, {28'd0, m_ctrl}); end
            rd(2'd1, d);
            total++; if (d !== m_preset) begin bad++; $display("FAIL rand_preset cyc%0d: got %h want %h", cyc, d, m_preset); end
            rd(2'd2, d);
            total++; if (d !== 32'(m_count)) begin bad++; $display("FAIL rand_count cyc%0d: got %0d want %0d", cyc, d, m_count); end
            total++; if (irq !== (m_flag & m_ctrl[3])) begin bad++; $display("FAIL rand_irq cyc%0d: got %b want %b", cyc, irq, m_flag & m_ctrl[3]); end
        end
    endtask

    initial begin
        test_reset();
        test_byte_writes();
        test_one_shot();
        test_auto_reload();
        test_abort();
        test_preset_zero();
        test_async_reset();
        test_collision();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
